// File: rtl/fetch_align_queue.sv
// fetch_align_queue
// Buffers 32-bit fetch words (each with a fetch error code and a prediction
// flag) and extracts one aligned RVC or RVI instruction per cycle at halfword
// granularity, including RVI instructions that straddle two fetch words.
// A lightweight predecode flags branches, direct jumps and indirect jumps.
//
// Ports:
//   s_clk_i, s_rst_i         clock, synchronous active-high reset
//   s_push_i, s_ready_o      fetch word write / queue has room
//   s_word_i, s_ferr_i,      fetch word, its error code and predictor hit
//   s_pred_i
//   s_flush_i,               discard content; first word after the flush
//   s_flush_half_i           starts at this halfword offset
//   s_valid_o, s_pop_i       aligned instruction available / consumed
//   s_instr_o, s_rvc_o       instruction ([31:16]=0 for RVC), 16-bit flag
//   s_ferr_o, s_align_err_o  fetch error, prediction on a split RVI first half
//   s_pred_o, s_pd_cf_o      prediction of last halfword's word, predecode
//   s_count_o                number of stored words
module fetch_align_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             s_clk_i,
  input  logic             s_rst_i,
  input  logic             s_push_i,
  output logic             s_ready_o,
  input  logic [31:0]      s_word_i,
  input  logic [2:0]       s_ferr_i,
  input  logic             s_pred_i,
  input  logic             s_flush_i,
  input  logic             s_flush_half_i,
  output logic             s_valid_o,
  input  logic             s_pop_i,
  output logic [31:0]      s_instr_o,
  output logic             s_rvc_o,
  output logic [2:0]       s_ferr_o,
  output logic             s_align_err_o,
  output logic             s_pred_o,
  output logic [1:0]       s_pd_cf_o,
  output logic [CNT_W-1:0] s_count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      wordMem_q [DEPTH];
  logic [2:0]       ferrMem_q [DEPTH];
  logic             predMem_q [DEPTH];
  logic [PTR_W-1:0] headPtr_q, headPtr_d, tailPtr_q, tailPtr_d, nextPtr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             off_q, off_d;

  logic [31:0] headWord, nextWord, instrRaw;
  logic [15:0] headHalf;
  logic [2:0]  headFerr, nextFerr, ferrRaw;
  logic        headPred, nextPred, predRaw, rvcRaw;
  logic        isRvi, headErr, spanning, validInt;
  logic        doPush, doPop, deq;
  logic [1:0]  pdRaw;

  // Head and next entries; the next entry only matters for a spanning RVI.
  assign nextPtr  = headPtr_q + 1'b1;
  assign headWord = wordMem_q[headPtr_q];
  assign nextWord = wordMem_q[nextPtr];
  assign headFerr = ferrMem_q[headPtr_q];
  assign nextFerr = ferrMem_q[nextPtr];
  assign headPred = predMem_q[headPtr_q];
  assign nextPred = predMem_q[nextPtr];
  assign headHalf = off_q ? headWord[31:16] : headWord[15:0];
  assign isRvi    = (headHalf[1:0] == 2'b11);
  assign headErr  = (headFerr != 3'b000);
  assign spanning = isRvi && off_q && !headErr;
  assign validInt = (count_q != '0) && (!spanning || (count_q >= CNT_W'(2)));

  assign s_ready_o = (count_q < CNT_W'(DEPTH));
  assign s_count_o = count_q;

  // Build the raw instruction and its side information from registered state.
  // An erroneous head word is emitted at once whatever its length, so the
  // decoder sees the error; its upper bits are only meaningful for a full RVI.
  always_comb begin
    instrRaw = {16'h0000, headHalf};
    rvcRaw   = 1'b0;
    ferrRaw  = 3'b000;
    predRaw  = headPred;
    if (headErr) begin
      ferrRaw = headFerr;
      if (isRvi && !off_q) begin
        instrRaw = headWord;
      end
    end else if (!isRvi) begin
      rvcRaw  = 1'b1;
      predRaw = off_q ? headPred : 1'b0;
    end else if (!off_q) begin
      instrRaw = headWord;
    end else begin
      instrRaw = {nextWord[15:0], headWord[31:16]};
      ferrRaw  = nextFerr;
      predRaw  = nextPred;
    end
  end

  // Predecode only looks at opcode/funct fields; illegal encodings pass
  // through. c.jr/c.jalr need rs1!=0 and rs2=0 to exclude c.mv/c.add/c.ebreak.
  always_comb begin
    pdRaw = 2'b00;
    if (!isRvi) begin
      if (instrRaw[1:0] == 2'b01) begin
        case (instrRaw[15:13])
          3'b001, 3'b101: pdRaw = 2'b10;
          3'b110, 3'b111: pdRaw = 2'b01;
          default:        pdRaw = 2'b00;
        endcase
      end else if (instrRaw[1:0] == 2'b10 && instrRaw[15:13] == 3'b100 &&
                   instrRaw[11:7] != 5'd0 && instrRaw[6:2] == 5'd0) begin
        pdRaw = 2'b11;
      end
    end else begin
      case (instrRaw[6:0])
        7'b1100011: pdRaw = 2'b01;
        7'b1101111: pdRaw = 2'b10;
        7'b1100111: pdRaw = (instrRaw[14:12] == 3'b000) ? 2'b11 : 2'b00;
        default:    pdRaw = 2'b00;
      endcase
    end
  end

  // Data outputs are forced to zero whenever no instruction is presented.
  assign s_valid_o     = validInt;
  assign s_instr_o     = validInt ? instrRaw : 32'h0;
  assign s_rvc_o       = validInt && rvcRaw;
  assign s_ferr_o      = validInt ? ferrRaw : 3'b000;
  assign s_align_err_o = validInt && spanning && headPred;
  assign s_pred_o      = validInt && predRaw;
  assign s_pd_cf_o     = validInt ? pdRaw : 2'b00;

  // Next-state: decide whether a pop consumes the head word and where the
  // halfword offset lands. A spanning RVI frees only the first word and
  // leaves the offset at the upper half of the following word. Flush wins.
  always_comb begin
    doPush    = s_push_i && s_ready_o;
    doPop     = s_pop_i && validInt;
    deq       = 1'b0;
    off_d     = off_q;
    if (doPop) begin
      if (headErr) begin
        deq   = 1'b1;
        off_d = 1'b0;
      end else if (!isRvi) begin
        deq   = off_q;
        off_d = !off_q;
      end else begin
        deq   = 1'b1;
        off_d = off_q;
      end
    end
    headPtr_d = deq ? nextPtr : headPtr_q;
    tailPtr_d = doPush ? tailPtr_q + 1'b1 : tailPtr_q;
    count_d   = count_q + CNT_W'(doPush) - CNT_W'(deq);
    if (s_flush_i) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
      off_d     = s_flush_half_i;
    end
  end

  // Control state register; reset behaves as a flush to offset zero.
  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
      off_q     <= 1'b0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
      off_q     <= off_d;
    end
  end

  // Entry storage needs no reset: every output is gated by the count.
  always_ff @(posedge s_clk_i) begin
    if (doPush && !s_flush_i && !s_rst_i) begin
      wordMem_q[tailPtr_q] <= s_word_i;
      ferrMem_q[tailPtr_q] <= s_ferr_i;
      predMem_q[tailPtr_q] <= s_pred_i;
    end
  end

  // Occupancy must stay within 0..DEPTH.
  assert property (@(posedge s_clk_i) disable iff (s_rst_i)
                   count_q <= CNT_W'(DEPTH));
  assert property (@(posedge s_clk_i) disable iff (s_rst_i)
                   !(deq && count_q == '0));

endmodule

// File: tb/tb_fetch_align_queue.sv
// tb_fetch_align_queue
// Directed bench for fetch_align_queue. Expected instructions are queued in
// a scoreboard when the words holding them are pushed, and compared in order
// whenever the bench pops an instruction from the DUT.
module tb_fetch_align_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             push, flush, flushHalf, pop, predIn;
  logic [31:0]      wordIn;
  logic [2:0]       ferrIn;
  logic             ready, valid, rvc, alignErr, predOut;
  logic [31:0]      instr;
  logic [2:0]       ferrOut;
  logic [1:0]       pdCf;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic        chkInstr;
    logic [31:0] instr;
    logic        rvc;
    logic [2:0]  ferr;
    logic        alignErr;
    logic        pred;
    logic [1:0]  pdCf;
  } expEntry_t;

  expEntry_t expQ[$];
  int checks = 0;
  int errors = 0;

  fetch_align_queue #(.DEPTH(DEPTH)) dut (
    .s_clk_i(clk), .s_rst_i(rst), .s_push_i(push), .s_ready_o(ready),
    .s_word_i(wordIn), .s_ferr_i(ferrIn), .s_pred_i(predIn),
    .s_flush_i(flush), .s_flush_half_i(flushHalf), .s_valid_o(valid),
    .s_pop_i(pop), .s_instr_o(instr), .s_rvc_o(rvc), .s_ferr_o(ferrOut),
    .s_align_err_o(alignErr), .s_pred_o(predOut), .s_pd_cf_o(pdCf),
    .s_count_o(count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic expEntry_t mkExp(input logic chk, input logic [31:0] i,
                                      input logic r, input logic [2:0] f,
                                      input logic ae, input logic p,
                                      input logic [1:0] cf);
    mkExp = '{chkInstr: chk, instr: i, rvc: r, ferr: f, alignErr: ae,
              pred: p, pdCf: cf};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic applyStimulus(input logic doPush, input logic [31:0] w,
                               input logic [2:0] f, input logic p,
                               input logic doPop, input logic doFlush,
                               input logic half);
    push = doPush; wordIn = w; ferrIn = f; predIn = p;
    pop = doPop; flush = doFlush; flushHalf = half;
    @(posedge clk);
    #1;
    push = 1'b0; wordIn = 32'h0; ferrIn = 3'b0; predIn = 1'b0;
    pop = 1'b0; flush = 1'b0; flushHalf = 1'b0;
  endtask

  // Compare the presented instruction against the oldest scoreboard entry.
  task automatic checkOutput(input string tag);
    expEntry_t e;
    if (expQ.size() == 0) begin
      checkVal({tag, ".sbEmpty"}, 32'(expQ.size()), 32'd1);
    end else begin
      e = expQ.pop_front();
      checkVal({tag, ".valid"}, 32'(valid), 32'd1);
      if (e.chkInstr) begin
        checkVal({tag, ".instr"}, instr, e.instr);
        checkVal({tag, ".pdCf"}, 32'(pdCf), 32'(e.pdCf));
      end
      checkVal({tag, ".rvc"}, 32'(rvc), 32'(e.rvc));
      checkVal({tag, ".ferr"}, 32'(ferrOut), 32'(e.ferr));
      checkVal({tag, ".alignErr"}, 32'(alignErr), 32'(e.alignErr));
      checkVal({tag, ".pred"}, 32'(predOut), 32'(e.pred));
    end
  endtask

  initial begin
    rst = 1'b1;
    push = 1'b0; wordIn = 32'h0; ferrIn = 3'b0; predIn = 1'b0;
    pop = 1'b0; flush = 1'b0; flushHalf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    checkVal("rst.valid", 32'(valid), 32'd0);
    checkVal("rst.ready", 32'(ready), 32'd1);
    checkVal("rst.count", 32'(count), 32'd0);
    checkVal("rst.instr", instr, 32'h0);

    // Two c.nop in one word.
    expQ.push_back(mkExp(1, 32'h0001, 1, 0, 0, 0, 2'b00));
    expQ.push_back(mkExp(1, 32'h0001, 1, 0, 0, 0, 2'b00));
    applyStimulus(1, 32'h0001_0001, 0, 0, 0, 0, 0);
    checkVal("nop.count1", 32'(count), 32'd1);
    checkOutput("nop.lo");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkVal("nop.countAfterLo", 32'(count), 32'd1);
    checkOutput("nop.hi");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkVal("nop.countEnd", 32'(count), 32'd0);
    checkVal("nop.validEnd", 32'(valid), 32'd0);

    // Spanning RVI after a flush to offset 1.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 32'h00B3_0000, 0, 0, 0, 0, 0);
    checkVal("span.halfValid", 32'(valid), 32'd0);
    checkVal("span.halfInstr", instr, 32'h0);
    expQ.push_back(mkExp(1, 32'h0000_00B3, 0, 0, 0, 0, 2'b00));
    expQ.push_back(mkExp(1, 32'h0000, 1, 0, 0, 0, 2'b00));
    applyStimulus(1, 32'h0000_0000, 0, 0, 0, 0, 0);
    checkVal("span.count2", 32'(count), 32'd2);
    checkOutput("span.rvi");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkVal("span.countAfter", 32'(count), 32'd1);
    checkOutput("span.tail");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkVal("span.countEnd", 32'(count), 32'd0);

    // Spanning RVI with prediction on the first word only.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 32'h00B3_0000, 0, 1, 0, 0, 0);
    expQ.push_back(mkExp(1, 32'h0000_00B3, 0, 0, 1, 0, 2'b00));
    applyStimulus(1, 32'h0000_0000, 0, 0, 0, 0, 0);
    checkOutput("alignErr");
    applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Faulty word holding an RVI lower half at offset 1.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    expQ.push_back(mkExp(0, 32'h0, 0, 3'b010, 0, 0, 2'b00));
    applyStimulus(1, 32'h00B3_0000, 3'b010, 0, 0, 0, 0);
    checkOutput("ferr");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkVal("ferr.countEnd", 32'(count), 32'd0);
    expQ.push_back(mkExp(1, 32'h0001, 1, 0, 0, 0, 2'b00));
    expQ.push_back(mkExp(1, 32'h0002, 1, 0, 0, 0, 2'b00));
    applyStimulus(1, 32'h0002_0001, 0, 0, 0, 0, 0);
    checkOutput("ferr.offZero");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("ferr.offOne");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    // JAL then c.jr ra; push and pop together keep the count.
    expQ.push_back(mkExp(1, 32'h0000_006F, 0, 0, 0, 1, 2'b10));
    applyStimulus(1, 32'h0000_006F, 0, 1, 0, 0, 0);
    checkOutput("jal");
    expQ.push_back(mkExp(1, 32'h8082, 1, 0, 0, 0, 2'b11));
    expQ.push_back(mkExp(1, 32'h0000, 1, 0, 0, 1, 2'b00));
    applyStimulus(1, 32'h0000_8082, 0, 1, 1, 0, 0);
    checkVal("jal.pushPopCount", 32'(count), 32'd1);
    checkOutput("cjr");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("cjr.upper");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkVal("cjr.countEnd", 32'(count), 32'd0);

    // Reset mid-operation restarts at offset zero.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 32'h0002_0001, 0, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    checkVal("midRst.count", 32'(count), 32'd0);
    expQ.push_back(mkExp(1, 32'h0001, 1, 0, 0, 0, 2'b00));
    applyStimulus(1, 32'h0002_0001, 0, 0, 0, 0, 0);
    checkOutput("midRst.offZero");
    applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Fill to DEPTH, overflow push dropped, then push+pop+flush together.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 32'h0001_0001, 0, 0, 0, 0, 0);
    end
    checkVal("full.count", 32'(count), 32'(DEPTH));
    checkVal("full.ready", 32'(ready), 32'd0);
    applyStimulus(1, 32'h0001_0001, 0, 0, 0, 0, 0);
    checkVal("full.dropCount", 32'(count), 32'(DEPTH));
    applyStimulus(1, 32'h0001_0001, 0, 0, 1, 1, 1);
    checkVal("flushAll.count", 32'(count), 32'd0);
    checkVal("flushAll.valid", 32'(valid), 32'd0);
    expQ.push_back(mkExp(1, 32'h0002, 1, 0, 0, 0, 2'b00));
    applyStimulus(1, 32'h0002_0001, 0, 0, 0, 0, 0);
    checkOutput("flushAll.offOne");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkVal("flushAll.countEnd", 32'(count), 32'd0);

    checkVal("sb.drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
